qa_drv_umf_chan_demux: RTL and testbench

//  Consumes the UMF chunk stream produced by qa_drv_fifo_from_host (rx_data/rx_rdy/rx_enable)
//  and parses UMF packet headers. Steers each packet (header + payload) to one of N_CHANNELS

---
 rtl/qa_drv_umf_chan_demux_if.sv | 27 ++
 rtl/qa_drv_umf_chan_demux.sv | 151 +++++++++++++++
 tb/tb_qa_drv_umf_chan_demux.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/qa_drv_umf_chan_demux_if.sv
// Handshake bundle between the host FIFO driver, the UMF channel demux and its consumers.
// master = demux side, slave = upstream source / downstream consumers side.
interface qa_drv_umf_chan_demux_if #(
    parameter int UMF_WIDTH  = 128,
    parameter int N_CHANNELS = 4
);
    logic [UMF_WIDTH-1:0]  in_data;
    logic                  in_rdy;
    logic                  in_enable;
    logic [UMF_WIDTH-1:0]  out_data;
    logic [N_CHANNELS-1:0] out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic [N_CHANNELS-1:0] out_deq;
    logic [31:0]           pkt_cnt;
    logic [15:0]           drop_cnt;

    modport master (
        input  in_data, in_rdy, out_deq,
        output in_enable, out_data, out_valid, out_sop, out_eop, pkt_cnt, drop_cnt
    );

    modport slave (
        output in_data, in_rdy, out_deq,
        input  in_enable, out_data, out_valid, out_sop, out_eop, pkt_cnt, drop_cnt
    );
endinterface

// File: rtl/qa_drv_umf_chan_demux.sv
// UMF packet demux: parses headers and steers each packet to one of N_CHANNELS via one-hot valid.
// Latency 1 cycle accept-to-valid; one-entry stage, upstream stalls while it is full and not dequeued.
module qa_drv_umf_chan_demux #(
    parameter int UMF_WIDTH  = 128,
    parameter int N_CHANNELS = 4
) (
    input  logic                          clk,
    input  logic                          resetb,
    qa_drv_umf_chan_demux_if.master       bus
);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           rem_q, rem_d;
    logic [7:0]            chan_q, chan_d;
    logic [N_CHANNELS-1:0] vld_q, vld_d;
    logic [UMF_WIDTH-1:0]  dat_q, dat_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [31:0]           pkt_q, pkt_d;
    logic [15:0]           drop_q, drop_d;

    logic [7:0]            hdr_id;
    logic [15:0]           hdr_len;
    logic                  id_ok;
    logic                  stage_full;
    logic                  deq_hit;
    logic                  slot_free;
    logic                  in_en;

    assign hdr_id     = bus.in_data[23:16];
    assign hdr_len    = bus.in_data[15:0];
    assign id_ok      = ({1'b0, hdr_id} < 9'(N_CHANNELS));
    assign stage_full = |vld_q;
    assign deq_hit    = |(bus.out_deq & vld_q);
    assign slot_free  = !stage_full || deq_hit;

    // Payload of a discarded packet never touches the stage, so it flows regardless of consumers.
    assign in_en = resetb && bus.in_rdy && ((state_q == ST_DROP) || slot_free);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        chan_d  = chan_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        pkt_d   = pkt_q;
        drop_d  = drop_q;

        if (deq_hit) begin
            vld_d = '0;
        end

        case (state_q)
            ST_HDR: begin
                if (in_en) begin
                    rem_d = hdr_len;
                    if (id_ok) begin
                        vld_d  = N_CHANNELS'(1) << hdr_id;
                        dat_d  = bus.in_data;
                        sop_d  = 1'b1;
                        eop_d  = (hdr_len == 16'd0);
                        chan_d = hdr_id;
                        pkt_d  = pkt_q + 32'd1;
                        if (hdr_len != 16'd0) begin
                            state_d = ST_PAY;
                        end
                    end else begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                        if (hdr_len != 16'd0) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_PAY: begin
                if (in_en) begin
                    vld_d = N_CHANNELS'(1) << chan_q;
                    dat_d = bus.in_data;
                    sop_d = 1'b0;
                    eop_d = (rem_q == 16'd1);
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                if (in_en) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= ST_HDR;
            rem_q   <= '0;
            chan_q  <= '0;
            vld_q   <= '0;
            dat_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            chan_q  <= chan_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_enable = in_en;
    assign bus.out_data  = dat_q;
    assign bus.out_valid = vld_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign bus.pkt_cnt   = pkt_q;
    assign bus.drop_cnt  = drop_q;

    a_deq_legal: assert property (@(posedge clk) disable iff (!resetb)
        ((bus.out_deq & ~bus.out_valid) == '0))
        else $fatal(1, "out_deq asserted on a channel without out_valid");

    a_valid_onehot: assert property (@(posedge clk) disable iff (!resetb)
        $onehot0(bus.out_valid))
        else $fatal(1, "out_valid is not one-hot-or-zero");

endmodule

// File: tb/tb_qa_drv_umf_chan_demux.sv
// Randomized scoreboard bench for the UMF channel demux; expected beats come from a packet-level model.
module tb_qa_drv_umf_chan_demux;
    localparam int W = 128;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] dat;
        int           ch;
        bit           sop;
        bit           eop;
    } beat_t;

    logic clk;
    logic resetb;

    qa_drv_umf_chan_demux_if #(.UMF_WIDTH(W), .N_CHANNELS(N)) bus ();

    qa_drv_umf_chan_demux #(.UMF_WIDTH(W), .N_CHANNELS(N)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    logic [W-1:0] in_q[$];
    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           exp_pkt  = 0;
    int           exp_drop = 0;
    bit           deq_en     = 0;
    bit           deq_all    = 1;
    bit           rdy_always = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input bit ok, input string name, input string info);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, info);
    endtask

    function automatic logic [W-1:0] rand_chunk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Packet-level model: the source stream gets every chunk, the consumer sees only in-range packets.
    task automatic send_pkt(input int id, input int p, input int keep = -1);
        logic [W-1:0] d;
        bit ok;
        int lim;
        ok  = (id < N);
        lim = (keep < 0) ? p + 1 : keep;
        d = rand_chunk();
        d[23:16] = 8'(id);
        d[15:0]  = 16'(p);
        in_q.push_back(d);
        if (ok) begin
            exp_pkt++;
            exp_q.push_back('{dat: d, ch: id, sop: 1'b1, eop: (p == 0)});
        end else if (exp_drop < 65535) begin
            exp_drop++;
        end
        for (int k = 1; k <= p && k < lim; k++) begin
            d = rand_chunk();
            in_q.push_back(d);
            if (ok) exp_q.push_back('{dat: d, ch: id, sop: 1'b0, eop: (k == p)});
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(c < budget, {name, "_drain"},
              $sformatf("in_q=%0d exp_q=%0d left after %0d cycles, want both 0", in_q.size(), exp_q.size(), c));
        in_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_cnts(input string name);
        check(bus.pkt_cnt == 32'(exp_pkt), {name, "_pkt_cnt"},
              $sformatf("got %0d want %0d", bus.pkt_cnt, exp_pkt));
        check(bus.drop_cnt == 16'(exp_drop), {name, "_drop_cnt"},
              $sformatf("got %0d want %0d", bus.drop_cnt, exp_drop));
    endtask

    // Source and consumer driver: inputs change on the falling edge only.
    initial begin
        bus.in_rdy  = 0;
        bus.in_data = '0;
        bus.out_deq = '0;
        forever begin
            @(negedge clk);
            if (in_q.size() > 0 && (rdy_always || $urandom_range(0, 3) != 0)) begin
                bus.in_rdy  = 1;
                bus.in_data = in_q[0];
            end else begin
                bus.in_rdy = 0;
            end
            if (deq_en && (deq_all || $urandom_range(0, 3) != 0)) bus.out_deq = bus.out_valid;
            else bus.out_deq = '0;
            #1;
            if (bus.in_rdy && bus.in_enable) void'(in_q.pop_front());
        end
    end

    // Monitor: pops the scoreboard for every beat a consumer takes; checks hold-stability under stall.
    initial begin
        logic [W-1:0] p_dat;
        logic [N-1:0] p_vld;
        logic [N-1:0] ev;
        logic         p_sop, p_eop;
        bit           p_ok;
        beat_t        e;
        p_ok = 0;
        forever begin
            @(negedge clk);
            #2;
            if (resetb && p_ok && p_vld != '0) begin
                check(bus.out_data == p_dat && bus.out_valid == p_vld &&
                      bus.out_sop == p_sop && bus.out_eop == p_eop, "stall_hold",
                      $sformatf("got vld=%b sop=%b eop=%b dat=%h, want held vld=%b sop=%b eop=%b dat=%h",
                                bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data,
                                p_vld, p_sop, p_eop, p_dat));
            end
            p_ok = 0;
            if (resetb && (bus.out_deq & bus.out_valid) != '0) begin
                if (exp_q.size() == 0) begin
                    check(0, "beat_unexpected",
                          $sformatf("got vld=%b dat=%h, want no beat", bus.out_valid, bus.out_data));
                end else begin
                    e  = exp_q.pop_front();
                    ev = '0;
                    ev[e.ch] = 1'b1;
                    check(bus.out_valid == ev && bus.out_data == e.dat &&
                          bus.out_sop == e.sop && bus.out_eop == e.eop, "beat",
                          $sformatf("got vld=%b sop=%b eop=%b dat=%h, want vld=%b sop=%b eop=%b dat=%h",
                                    bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data,
                                    ev, e.sop, e.eop, e.dat));
                end
            end else if (resetb) begin
                p_ok  = 1;
                p_vld = bus.out_valid;
                p_dat = bus.out_data;
                p_sop = bus.out_sop;
                p_eop = bus.out_eop;
            end
        end
    end

    initial begin
        resetb = 0;
        repeat (3) @(negedge clk);
        #1;
        check(bus.out_valid == '0 && bus.out_sop == 0 && bus.out_eop == 0 && bus.out_data == '0,
              "reset_outputs", $sformatf("got vld=%b sop=%b eop=%b dat=%h, want all zero",
                                         bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data));
        check(bus.in_enable == 0, "reset_in_enable", $sformatf("got %b want 0", bus.in_enable));
        check_cnts("reset");
        @(negedge clk);
        resetb  = 1;
        deq_en  = 1;

        // Single in-range packet, then a dropped packet followed by a zero-length header.
        send_pkt(2, 3);
        drain("t1", 100);
        check_cnts("t1");
        send_pkt(7, 2);
        send_pkt(0, 0);
        drain("t2", 100);
        check_cnts("t2");

        // Consumer stall: header sits in the stage, upstream must stay blocked.
        deq_en = 0;
        send_pkt(1, 2);
        repeat (6) @(negedge clk);
        #1;
        check(bus.in_enable == 0, "stall_in_enable", $sformatf("got %b want 0", bus.in_enable));
        check(in_q.size() == 2, "stall_backlog", $sformatf("got %0d chunks pending want 2", in_q.size()));
        deq_en = 1;
        drain("t3", 100);

        send_pkt(0, 1);
        send_pkt(3, 1);
        drain("t4", 100);
        check_cnts("t4");

        // Random traffic with random source gaps and consumer stalls.
        deq_all    = 0;
        rdy_always = 0;
        for (int i = 0; i < 80; i++) begin
            send_pkt($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5));
        end
        drain("rand", 5000);
        check_cnts("rand");

        // Reset in the middle of a payload: 4 of 9 chunks go out, then the packet is abandoned.
        deq_all    = 1;
        rdy_always = 1;
        send_pkt(1, 8, 4);
        drain("t5_pre", 100);
        deq_en = 0;
        @(negedge clk);
        resetb = 0;
        @(negedge clk);
        resetb = 1;
        #1;
        exp_pkt  = 0;
        exp_drop = 0;
        check(bus.out_valid == '0, "t5_valid", $sformatf("got %b want 0", bus.out_valid));
        check_cnts("t5_reset");
        deq_en = 1;
        send_pkt(2, 0);
        drain("t5_post", 100);
        check_cnts("t5_post");

        // Drop counter: exact count then saturation.
        for (int i = 0; i < 300; i++) send_pkt(200, 0);
        drain("t6a", 1000);
        check_cnts("t6a");
        for (int i = 0; i < 65534 - 300; i++) send_pkt(255, 0);
        drain("t6b", 70000);
        check(bus.drop_cnt == 16'hFFFE, "t6_fffe", $sformatf("got %h want fffe", bus.drop_cnt));
        for (int i = 0; i < 3; i++) send_pkt(4, 0);
        drain("t6c", 100);
        check(bus.drop_cnt == 16'hFFFF, "t6_sat", $sformatf("got %h want ffff", bus.drop_cnt));
        check_cnts("t6c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
